// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, handshakes instruction memory, hands {pc, instruction} to decode.
// Latency: instruction valid the cycle after imem_ready; best case one instruction every 2 cycles.
// Backpressure: stall parks the stage in HOLD indefinitely; the memory wait in REQ is unbounded.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] branch_ofs;

  assign pc_plus4   = pc_out + 32'd4;
  assign imem_addr  = pc_out;
  assign branch_ofs = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Register jump outranks jump, which outranks a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)
      next_pc = jr_target & 32'hFFFF_FFFC;
    else if (jump)
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + branch_ofs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pc_out          <= RESET_PC;
      instruction_out <= 32'd0;
      instr_valid     <= 1'b0;
      fetch_count     <= 32'd0;
      imem_req        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            instruction_out <= imem_rdata;
            instr_valid     <= 1'b1;
            fetch_count     <= fetch_count + 32'd1;
            imem_req        <= 1'b0;
            state           <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_out      <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected fetch addresses and instruction words are queued
// when stimulus is driven and popped when the DUT issues a request or delivers an instruction.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [31:0] fetch_count;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [31:0] exp_count = 32'd0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .jump(jump), .jump_target(jump_target),
    .jump_reg(jump_reg), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction_out(instruction_out), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL wait_req: imem_req=%b after %0d cycles, required 1", imem_req, n);
    end
  endtask

  // Precondition: in HOLD at a negedge. Drives one advance and queues the expected next PC.
  task automatic advance(input logic jr, input logic [31:0] jrt, input logic j,
                         input logic [25:0] jt, input logic br, input logic [15:0] bimm,
                         input logic [31:0] exp_pc);
    jump_reg = jr; jr_target = jrt; jump = j; jump_target = jt;
    branch_taken = br; branch_imm = bimm; imem_ready = 1'b0;
    stall = 1'b0;
    addr_q.push_back(exp_pc);
    @(negedge clk);
    stall = 1'b1;
    jump_reg = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jr_target = 32'hFFFF_FFFF; jump_target = 26'h3FF_FFFF; branch_imm = 16'h7FFF;
  endtask

  // Waits for REQ, checks the address, holds ready low for `delay` cycles, then delivers `data`.
  task automatic fetch_one(input logic [31:0] data, input int delay);
    logic [31:0] ea;
    logic [31:0] ed;
    wait_req();
    ea = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_DEAD;
    tests++;
    if (imem_addr !== ea) begin
      fails++;
      $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, ea);
    end
    for (int i = 0; i <= delay; i++) begin
      tests++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc_out !== ea) begin
        fails++;
        $display("FAIL req_wait[%0d]: req=%b valid=%b pc=%h required 1 0 %h",
                 i, imem_req, instr_valid, pc_out, ea);
      end
      if (i == delay) begin
        imem_ready = 1'b1; imem_rdata = data; data_q.push_back(data);
      end else begin
        imem_ready = 1'b0; imem_rdata = ~data;
      end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    ed = (data_q.size() > 0) ? data_q.pop_front() : 32'hDEAD_DEAD;
    tests++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instruction_out !== ed) begin
      fails++;
      $display("FAIL deliver: valid=%b req=%b instr=%h required 1 0 %h",
               instr_valid, imem_req, instruction_out, ed);
    end
    tests++;
    if (fetch_count !== exp_count || pc_out !== ea) begin
      fails++;
      $display("FAIL deliver_state: count=%0d pc=%h required %0d %h",
               fetch_count, pc_out, exp_count, ea);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    jump_reg = 1'b0; jr_target = 32'd0; jump = 1'b0; jump_target = 26'd0;
    branch_taken = 1'b0; branch_imm = 16'd0;
    repeat (2) @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 32'd0 ||
        pc_out !== 32'd0 || instruction_out !== 32'd0 || imem_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: req=%b valid=%b count=%0d pc=%h instr=%h required 0 0 0 0 0",
               imem_req, instr_valid, fetch_count, pc_out, instruction_out);
    end
    tests++;
    if (pc_plus4 !== 32'd4) begin
      fails++;
      $display("FAIL reset_pc_plus4: %h required 00000004", pc_plus4);
    end
    reset = 1'b0;
    exp_count = 32'd0;
  endtask

  task automatic test_sequential();
    logic [31:0] ea;
    for (int k = 0; k < 4; k++) addr_q.push_back(32'(k * 4));
    imem_ready = 1'b1; imem_rdata = 32'h2129_0001; stall = 1'b0;
    wait_req();
    for (int k = 0; k < 4; k++) begin
      ea = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_DEAD;
      tests++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== ea) begin
        fails++;
        $display("FAIL seq_req[%0d]: req=%b valid=%b addr=%h required 1 0 %h",
                 k, imem_req, instr_valid, imem_addr, ea);
      end
      data_q.push_back(32'h2129_0001);
      exp_count = exp_count + 32'd1;
      @(negedge clk);
      tests++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instruction_out !== data_q.pop_front() ||
          fetch_count !== exp_count) begin
        fails++;
        $display("FAIL seq_valid[%0d]: valid=%b req=%b instr=%h count=%0d required 1 0 21290001 %0d",
                 k, instr_valid, imem_req, instruction_out, fetch_count, exp_count);
      end
      if (k < 3) @(negedge clk);
    end
    stall = 1'b1; imem_ready = 1'b0;
  endtask

  task automatic test_mem_wait();
    advance(1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0010);
    fetch_one(32'h0A2A_E52B, 5);
  endtask

  task automatic test_branch();
    advance(1'b1, 32'h0000_0040, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0040);
    fetch_one(32'h1111_0000, 0);
    advance(1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'hFFFE, 32'h0000_003C);
    fetch_one(32'h1111_0001, 1);
    advance(1'b1, 32'h0000_0040, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0040);
    fetch_one(32'h1111_0002, 0);
    advance(1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'h0003, 32'h0000_0050);
    fetch_one(32'h1111_0003, 0);
  endtask

  task automatic test_jump_priority();
    advance(1'b1, 32'h1000_0000, 1'b0, 26'd0, 1'b0, 16'd0, 32'h1000_0000);
    fetch_one(32'h2222_0000, 0);
    advance(1'b1, 32'h0040_0007, 1'b1, 26'h2A8E52B, 1'b1, 16'h0100, 32'h0040_0004);
    fetch_one(32'h2222_0001, 0);
    advance(1'b1, 32'h1000_0000, 1'b0, 26'd0, 1'b0, 16'd0, 32'h1000_0000);
    fetch_one(32'h2222_0002, 0);
    advance(1'b0, 32'h0040_0007, 1'b1, 26'h2A8E52B, 1'b1, 16'h0100, 32'h1AA3_94AC);
    fetch_one(32'h2222_0003, 0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      branch_taken = i[0]; branch_imm = 16'h0100;
      imem_ready = 1'b1; imem_rdata = 32'hBAD0_0000 + 32'(i);
      @(negedge clk);
      tests++;
      if (pc_out !== 32'h1AA3_94AC || instruction_out !== 32'h2222_0003 ||
          fetch_count !== exp_count || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h count=%0d req=%b valid=%b required 1aa394ac 22220003 %0d 0 1",
                 i, pc_out, instruction_out, fetch_count, imem_req, instr_valid, exp_count);
      end
    end
    advance(1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'h0010, 32'h1AA3_94F0);
    fetch_one(32'h3333_0000, 2);
  endtask

  task automatic test_wrap();
    advance(1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0, 16'd0, 32'hFFFF_FFFC);
    fetch_one(32'h4444_0000, 0);
    tests++;
    if (pc_plus4 !== 32'd0) begin
      fails++;
      $display("FAIL pc_plus4_wrap: %h required 00000000", pc_plus4);
    end
    advance(1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0000);
    fetch_one(32'h4444_0001, 0);
  endtask

  task automatic test_async_reset();
    advance(1'b1, 32'h0000_0080, 1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0080);
    wait_req();
    tests++;
    if (imem_addr !== addr_q.pop_front()) begin
      fails++;
      $display("FAIL pre_reset_addr: imem_addr=%h required 00000080", imem_addr);
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 32'd0 ||
        pc_out !== 32'd0 || instruction_out !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: req=%b valid=%b count=%0d pc=%h instr=%h required 0 0 0 0 0",
               imem_req, instr_valid, fetch_count, pc_out, instruction_out);
    end
    imem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 32'd0;
    addr_q.delete(); data_q.delete();
    addr_q.push_back(32'h0000_0000);
    fetch_one(32'h5555_0000, 1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mem_wait();
    test_branch();
    test_jump_priority();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
